// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train generator: state encoding and default widths.
package pulse_train_pkg;

   localparam int unsigned DEF_CNT_W = 16;
   localparam int unsigned DEF_N_W   = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      HIGH = ST_HIGH,
      LOW  = ST_LOW
   } state_t;

endpackage

// File: rtl/pulse_phase_counter.sv
// Loadable down-counter timing one HIGH or LOW phase; tc_c marks the last cycle of the phase.
module pulse_phase_counter
   import pulse_train_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc_c
);

   logic [CNT_W-1:0] cnt;

   // Holds at zero once expired so an idle counter never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign tc_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Burst generator: turns a one-cycle start into n registered pulses of programmable high/low time.
module pulse_train_gen
   import pulse_train_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned N_W   = DEF_N_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [N_W-1:0]   n_pulses,
   output logic             out,
   output logic             out_rise,
   output logic             out_fall,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [N_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0] hl_q, hl_d, ll_q, ll_d;
   logic [CNT_W-1:0] hl_in, ll_in, ld_val;
   logic             out_d, rise_d, fall_d, busy_d, done_d;
   logic             ld, tc;

   // Zero-length phases are stretched to one cycle.
   assign hl_in = (high_len == '0) ? CNT_W'(1) : high_len;
   assign ll_in = (low_len  == '0) ? CNT_W'(1) : low_len;

   pulse_phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .tc_c     (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         hl_q     <= '0;
         ll_q     <= '0;
         out      <= 1'b0;
         out_rise <= 1'b0;
         out_fall <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         hl_q     <= hl_d;
         ll_q     <= ll_d;
         out      <= out_d;
         out_rise <= rise_d;
         out_fall <= fall_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      hl_d    = hl_q;
      ll_d    = ll_q;
      out_d   = out;
      busy_d  = busy;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      done_d  = 1'b0;
      ld      = 1'b0;
      ld_val  = hl_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (n_pulses != '0) begin
                  hl_d    = hl_in;
                  ll_d    = ll_in;
                  rem_d   = n_pulses;
                  out_d   = 1'b1;
                  rise_d  = 1'b1;
                  busy_d  = 1'b1;
                  ld      = 1'b1;
                  ld_val  = hl_in;
                  state_d = HIGH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         HIGH: begin
            if (tc) begin
               out_d  = 1'b0;
               fall_d = 1'b1;
               rem_d  = rem_q - N_W'(1);
               // Last pulse ends the burst directly, with no trailing low phase.
               if (rem_q == N_W'(1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ld      = 1'b1;
                  ld_val  = ll_q;
                  state_d = LOW;
               end
            end
         end
         LOW: begin
            if (tc) begin
               out_d   = 1'b1;
               rise_d  = 1'b1;
               ld      = 1'b1;
               ld_val  = hl_q;
               state_d = HIGH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen with an edge-detector loopback on out.
module tb_pulse_train_gen;

   localparam int unsigned CW = 4;
   localparam int unsigned NW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] high_len = '0;
   logic [CW-1:0] low_len = '0;
   logic [NW-1:0] n_pulses = '0;
   logic          out, out_rise, out_fall, busy, done;

   int checks = 0;
   int failures = 0;

   pulse_train_gen #(
      .CNT_W (CW),
      .N_W   (NW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .high_len (high_len),
      .low_len  (low_len),
      .n_pulses (n_pulses),
      .out      (out),
      .out_rise (out_rise),
      .out_fall (out_fall),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Synchronous 1-bit edge detector watching out independently of the DUT strobes.
   logic lb_prev = 1'b0;
   int   lb_rises = 0;
   int   lb_falls = 0;
   always @(posedge clk) begin
      if (out && !lb_prev) lb_rises++;
      if (!out && lb_prev) lb_falls++;
      lb_prev <= out;
   end

   // Pulses start, then records ncyc cycles MSB-first (first recorded cycle is the one after start).
   task automatic burst(input logic [CW-1:0] hl, input logic [CW-1:0] ll, input logic [NW-1:0] n,
                        input int ncyc, input int poke, input int rst_at, input bit restart,
                        output logic [127:0] w, output logic [127:0] dv, output logic [127:0] bv,
                        output logic [127:0] rv, output logic [127:0] fv,
                        output int r, output int f, output int d, output int lr, output int lf);
      int lr0, lf0;
      high_len = hl;
      low_len  = ll;
      n_pulses = n;
      start    = 1'b1;
      lr0 = lb_rises;
      lf0 = lb_falls;
      @(posedge clk); #1;
      start = 1'b0;
      w = '0; dv = '0; bv = '0; rv = '0; fv = '0;
      r = 0; f = 0; d = 0;
      for (int i = 0; i < ncyc; i++) begin
         w  = {w[126:0], out};
         dv = {dv[126:0], done};
         bv = {bv[126:0], busy};
         rv = {rv[126:0], out_rise};
         fv = {fv[126:0], out_fall};
         r += int'(out_rise);
         f += int'(out_fall);
         d += int'(done);
         if (i == poke) high_len = 4'd9;
         start = (i == poke) || (restart && done);
         rst   = (i == rst_at);
         @(posedge clk); #1;
      end
      start = 1'b0;
      rst   = 1'b0;
      lr = lb_rises - lr0;
      lf = lb_falls - lf0;
   endtask

   logic [127:0] w, dv, bv, rv, fv, e;
   int r, f, d, lr, lf;

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out, out_rise, out_fall, busy, done} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 00000", {out, out_rise, out_fall, busy, done});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      burst(4'd3, 4'd5, 3'd1, 6, -1, -1, 1'b0, w, dv, bv, rv, fv, r, f, d, lr, lf);
      checks++;
      if (w[5:0] !== 6'b111000) begin failures++; $display("FAIL single_out: got %b expected 111000", w[5:0]); end
      checks++;
      if (dv[5:0] !== 6'b000100) begin failures++; $display("FAIL single_done: got %b expected 000100", dv[5:0]); end
      checks++;
      if (fv[5:0] !== 6'b000100) begin failures++; $display("FAIL single_fall: got %b expected 000100", fv[5:0]); end
      checks++;
      if (rv[5:0] !== 6'b100000) begin failures++; $display("FAIL single_rise: got %b expected 100000", rv[5:0]); end
      checks++;
      if (bv[5:0] !== 6'b111000) begin failures++; $display("FAIL single_busy: got %b expected 111000", bv[5:0]); end
   endtask

   task automatic test_train();
      burst(4'd2, 4'd4, 3'd3, 16, -1, -1, 1'b0, w, dv, bv, rv, fv, r, f, d, lr, lf);
      checks++;
      if (w[15:0] !== 16'b1100001100001100) begin failures++; $display("FAIL train_out: got %b expected 1100001100001100", w[15:0]); end
      checks++;
      if (bv[15:0] !== 16'b1111111111111100) begin failures++; $display("FAIL train_busy: got %b expected 1111111111111100", bv[15:0]); end
      checks++;
      if (dv[15:0] !== 16'b0000000000000010) begin failures++; $display("FAIL train_done: got %b expected 0000000000000010", dv[15:0]); end
      checks++;
      if (r != 3 || f != 3) begin failures++; $display("FAIL train_strobes: got rise=%0d fall=%0d expected 3/3", r, f); end
      checks++;
      if (lr != 3 || lf != 3) begin failures++; $display("FAIL train_loopback: got rise=%0d fall=%0d expected 3/3", lr, lf); end
      checks++;
      if (d != 1) begin failures++; $display("FAIL train_done_count: got %0d expected 1", d); end
   endtask

   task automatic test_zero_fields();
      burst(4'd0, 4'd0, 3'd2, 5, -1, -1, 1'b0, w, dv, bv, rv, fv, r, f, d, lr, lf);
      checks++;
      if (w[4:0] !== 5'b10100) begin failures++; $display("FAIL zero_len_out: got %b expected 10100", w[4:0]); end
      checks++;
      if (dv[4:0] !== 5'b00010) begin failures++; $display("FAIL zero_len_done: got %b expected 00010", dv[4:0]); end
      checks++;
      if (bv[4:0] !== 5'b11100) begin failures++; $display("FAIL zero_len_busy: got %b expected 11100", bv[4:0]); end
      burst(4'd5, 4'd5, 3'd0, 4, -1, -1, 1'b0, w, dv, bv, rv, fv, r, f, d, lr, lf);
      checks++;
      if (w[3:0] !== 4'b0000) begin failures++; $display("FAIL empty_out: got %b expected 0000", w[3:0]); end
      checks++;
      if (dv[3:0] !== 4'b1000) begin failures++; $display("FAIL empty_done: got %b expected 1000", dv[3:0]); end
      checks++;
      if (bv[3:0] !== 4'b0000 || r != 0) begin failures++; $display("FAIL empty_busy: got busy=%b rises=%0d expected 0000/0", bv[3:0], r); end
   endtask

   task automatic test_back_to_back();
      int waited;
      burst(4'd4, 4'd2, 3'd2, 14, 2, -1, 1'b1, w, dv, bv, rv, fv, r, f, d, lr, lf);
      checks++;
      if (w[13:0] !== 14'b11110011110111) begin failures++; $display("FAIL ignored_out: got %b expected 11110011110111", w[13:0]); end
      checks++;
      if (dv[13:0] !== 14'b00000000001000) begin failures++; $display("FAIL ignored_done: got %b expected 00000000001000", dv[13:0]); end
      checks++;
      if (rv[13:0] !== 14'b10000010000100) begin failures++; $display("FAIL restart_rise: got %b expected 10000010000100", rv[13:0]); end
      waited = 0;
      while (busy && waited < 60) begin
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL restart_drain: got busy=%b expected 0 within 60 cycles", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      burst(4'd10, 4'd2, 3'd5, 18, -1, 14, 1'b0, w, dv, bv, rv, fv, r, f, d, lr, lf);
      checks++;
      if (w[17:0] !== 18'b111111111100111000) begin failures++; $display("FAIL abort_out: got %b expected 111111111100111000", w[17:0]); end
      checks++;
      if (bv[17:0] !== 18'b111111111111111000) begin failures++; $display("FAIL abort_busy: got %b expected 111111111111111000", bv[17:0]); end
      checks++;
      if (fv[17:0] !== 18'b000000000010000000) begin failures++; $display("FAIL abort_fall: got %b expected 000000000010000000", fv[17:0]); end
      checks++;
      if (d != 0) begin failures++; $display("FAIL abort_done: got %0d expected 0", d); end
      burst(4'd3, 4'd1, 3'd2, 9, -1, -1, 1'b0, w, dv, bv, rv, fv, r, f, d, lr, lf);
      checks++;
      if (w[8:0] !== 9'b111011100) begin failures++; $display("FAIL fresh_out: got %b expected 111011100", w[8:0]); end
      checks++;
      if (dv[8:0] !== 9'b000000010 || r != 2 || f != 2) begin
         failures++;
         $display("FAIL fresh_done: got done=%b rise=%0d fall=%0d expected 000000010/2/2", dv[8:0], r, f);
      end
   endtask

   task automatic test_max_width();
      burst(4'd15, 4'd1, 3'd7, 113, -1, -1, 1'b0, w, dv, bv, rv, fv, r, f, d, lr, lf);
      e = '0;
      for (int p = 0; p < 7; p++) begin
         for (int k = 0; k < 15; k++) e = {e[126:0], 1'b1};
         if (p < 6) e = {e[126:0], 1'b0};
      end
      e = {e[125:0], 2'b00};
      checks++;
      if (w[112:0] !== e[112:0]) begin failures++; $display("FAIL max_out: got %b expected %b", w[112:0], e[112:0]); end
      checks++;
      if (dv[112:0] !== 113'd2) begin failures++; $display("FAIL max_done: got %b expected done only at cycle 111", dv[112:0]); end
      checks++;
      if (r != 7 || f != 7 || lr != 7 || lf != 7) begin
         failures++;
         $display("FAIL max_edges: got rise=%0d fall=%0d lb_rise=%0d lb_fall=%0d expected all 7", r, f, lr, lf);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_train();
      test_zero_fields();
      test_back_to_back();
      test_reset_abort();
      test_max_width();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
